// File: rtl/inst_mem_arb_pkg.sv
// Shared types and defaults for the instruction-RAM arbiter.
// Holds the FSM state enum, the read-owner tag enum and default widths.
package inst_mem_arb_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        ARB  = 1'b0,
        LOAD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    // Priority register encoding; bit index 0 of req/gnt is port A.
    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

endpackage

// File: rtl/inst_mem_arb_rr2.sv
// Two-way round-robin grant with a one-bit priority register.
// Ports: clk, reset (sync, active high), enable, req[1:0] in; gnt[1:0] out.
module inst_mem_arb_rr2
    import inst_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio == PRIO_A) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Priority only moves on a real conflict, so a lone requester
    // never steals the other side's next turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= PRIO_A;
        end else if (enable && (&req)) begin
            prio <= ~prio;
        end
    end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares one single-port instruction RAM between fetch (A, read-only) and
// loader/debug (B, read/write) with round-robin and a loader lock mode.
// Ports: clk, reset (sync, active high); a_req/a_addr -> a_gnt/a_rvalid/
// a_rdata; b_req/b_write/b_addr/b_be/b_wdata/b_lock -> b_gnt/b_rvalid/
// b_rdata; locked; mem_* RAM interface (read data one cycle after address).
// Optional macro INST_MEM_ARB_PERF_EN adds conflict_cnt and a_block_cnt.
module inst_mem_arbiter
    import inst_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [BE_W-1:0]   b_be,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              locked,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
`ifdef INST_MEM_ARB_PERF_EN
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       a_block_cnt,
`endif
    input  logic [DATA_W-1:0] mem_readdata
);

    state_t     state;
    state_t     state_nxt;
    owner_t     owner;
    owner_t     owner_nxt;
    logic       rr_en;
    logic [1:0] rr_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // b_lock is only looked at here; the grant in the cycle it rises
    // still comes from the round-robin.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB:     if (b_lock)  state_nxt = LOAD;
            LOAD:    if (!b_lock) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    assign rr_en = !reset && (state == ARB);

    inst_mem_arb_rr2 u_rr2 (
        .clk    (clk),
        .reset  (reset),
        .enable (rr_en),
        .req    ({b_req, a_req}),
        .gnt    (rr_gnt)
    );

    always_comb begin
        locked = !reset && (state == LOAD);
        a_gnt  = rr_gnt[0];
        b_gnt  = rr_gnt[1];
        if (state == LOAD) begin
            a_gnt = 1'b0;
            b_gnt = b_req && !reset;
        end
    end

    always_comb begin
        mem_chipselect = a_gnt || b_gnt;
        mem_write      = b_gnt && b_write;
        mem_address    = b_gnt ? b_addr : a_addr;
        mem_writedata  = b_wdata;
        mem_clken      = !reset;
        mem_byteenable = '0;
        if (b_gnt) begin
            mem_byteenable = b_write ? b_be : '1;
        end else if (a_gnt) begin
            mem_byteenable = '1;
        end
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        if (a_gnt) begin
            owner_nxt = OWN_A;
        end else if (b_gnt && !b_write) begin
            owner_nxt = OWN_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // Gating with reset drops a read that was in flight when reset rose.
    assign a_rvalid = !reset && (owner == OWN_A);
    assign b_rvalid = !reset && (owner == OWN_B);
    assign a_rdata  = mem_readdata;
    assign b_rdata  = mem_readdata;

`ifdef INST_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
            a_block_cnt  <= '0;
        end else begin
            if ((state == ARB) && a_req && b_req
                && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            if ((state == LOAD) && a_req
                && (a_block_cnt != '1)) begin
                a_block_cnt <= a_block_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Self-checking bench for inst_mem_arbiter with a RAM model,
// a reference arbiter model and per-port read-data scoreboards.
module tb_inst_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0;
    logic          b_write = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [BW-1:0] b_be = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_lock = 1'b0;
    logic          b_gnt, b_rvalid, locked;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata = '0;
`ifdef INST_MEM_ARB_PERF_EN
    logic [31:0]   conflict_cnt, a_block_cnt;
`endif

    always #5 clk = ~clk;

    inst_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .a_req          (a_req),
        .a_addr         (a_addr),
        .a_gnt          (a_gnt),
        .a_rvalid       (a_rvalid),
        .a_rdata        (a_rdata),
        .b_req          (b_req),
        .b_write        (b_write),
        .b_addr         (b_addr),
        .b_be           (b_be),
        .b_wdata        (b_wdata),
        .b_lock         (b_lock),
        .b_gnt          (b_gnt),
        .b_rvalid       (b_rvalid),
        .b_rdata        (b_rdata),
        .locked         (locked),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
`ifdef INST_MEM_ARB_PERF_EN
        .conflict_cnt   (conflict_cnt),
        .a_block_cnt    (a_block_cnt),
`endif
        .mem_readdata   (mem_readdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
    end

    // Single-port RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int k = 0; k < BW; k++) begin
                    if (mem_byteenable[k]) begin
                        ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
                    end
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference model state.
    logic       m_load = 1'b0;
    logic       m_prio = 1'b0;
    logic [1:0] m_own = 2'd0;
    logic       m_ea = 1'b0;
    logic       m_eb = 1'b0;
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];

    always @(negedge clk) begin
        logic ea, eb, eav, ebv;
        logic [BW-1:0] ebe;
        ea = 1'b0;
        eb = 1'b0;
        if (!reset) begin
            if (m_load) begin
                eb = b_req;
            end else if (a_req && b_req) begin
                ea = (m_prio == 1'b0);
                eb = (m_prio == 1'b1);
            end else begin
                ea = a_req;
                eb = b_req;
            end
        end
        chk("a_gnt", a_gnt, ea);
        chk("b_gnt", b_gnt, eb);
        chk("locked", locked, m_load && !reset);
        chk("mem_clken", mem_clken, !reset);
        chk("mem_cs", mem_chipselect, ea || eb);
        chk("mem_write", mem_write, eb && b_write);
        ebe = eb ? (b_write ? b_be : 4'hF) : (ea ? 4'hF : 4'h0);
        chk("mem_be", mem_byteenable, ebe);
        if (ea) chk("mem_addr_a", mem_address, a_addr);
        if (eb) chk("mem_addr_b", mem_address, b_addr);
        // Return path for the read granted in the previous cycle.
        eav = !reset && (m_own == 2'd1);
        ebv = !reset && (m_own == 2'd2);
        chk("a_rvalid", a_rvalid, eav);
        chk("b_rvalid", b_rvalid, ebv);
        if (eav && a_rvalid) begin
            if (qa.size() == 0) chk("a_queue", 0, 1);
            else chk("a_rdata", a_rdata, qa.pop_front());
        end
        if (ebv && b_rvalid) begin
            if (qb.size() == 0) chk("b_queue", 0, 1);
            else chk("b_rdata", b_rdata, qb.pop_front());
        end
        // Record this cycle's accesses.
        if (ea) qa.push_back(ref_mem[a_addr]);
        if (eb && !b_write) qb.push_back(ref_mem[b_addr]);
        if (eb && b_write) begin
            chk("mem_wdata", mem_writedata, b_wdata);
            for (int k = 0; k < BW; k++) begin
                if (b_be[k]) ref_mem[b_addr][8*k +: 8] = b_wdata[8*k +: 8];
            end
        end
        m_ea = ea;
        m_eb = eb;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_load = 1'b0;
            m_prio = 1'b0;
            m_own  = 2'd0;
            qa.delete();
            qb.delete();
        end else begin
            m_own = m_ea ? 2'd1 : ((m_eb && !b_write) ? 2'd2 : 2'd0);
            if (!m_load && a_req && b_req) m_prio = ~m_prio;
            m_load = b_lock;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_req = 1'b0;
        b_req = 1'b0;
        b_write = 1'b0;
        b_lock = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // A-only reads at consecutive addresses.
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1;
            a_addr = AW'(i);
            step();
        end
        idle(2);

        // B partial write then readback at the top address.
        b_req = 1'b1;
        b_write = 1'b1;
        b_addr = 13'h1FFF;
        b_be = 4'b0011;
        b_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("s2_be", mem_byteenable, 4'b0011);
        step();
        b_write = 1'b0;
        b_be = 4'b0000;
        step();
        b_req = 1'b0;
        @(negedge clk);
        chk("s2_rd", b_rdata,
            (init_word(13'h1FFF) & 32'hFFFF_0000) | 32'h0000_BEEF);
        idle(2);

        // Continuous conflict from reset: grants alternate A, B.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a_req = 1'b1;
            a_addr = AW'(16 + i);
            b_req = 1'b1;
            b_addr = AW'(13'h100 + i);
            @(negedge clk);
            chk("s3_a_alt", a_gnt, (i % 2) == 0);
            chk("s3_b_alt", b_gnt, (i % 2) == 1);
            step();
        end
        idle(2);

        // Loader lock held while A keeps requesting.
        a_req = 1'b1;
        a_addr = 13'h0040;
        b_lock = 1'b1;
        step();
        for (int i = 1; i <= 10; i++) begin
            b_req = (i >= 3 && i <= 5);
            b_addr = AW'(13'h0200 + i);
            b_lock = (i != 10);
            @(negedge clk);
            chk("s4_locked", locked, 1);
            chk("s4_a_blk", a_gnt, 0);
            step();
        end
        b_req = 1'b0;
        @(negedge clk);
        chk("s4_unlock", locked, 0);
        chk("s4_a_back", a_gnt, 1);
`ifdef INST_MEM_ARB_PERF_EN
        chk("conflict_cnt", conflict_cnt, 6);
        chk("a_block_cnt", a_block_cnt, 10);
`endif
        step();
        idle(2);

        // Reset while an A read is in flight.
        a_req = 1'b1;
        a_addr = 13'h0005;
        step();
        a_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("s5_drop", a_rvalid, 0);
        step();
        reset = 1'b0;
        a_req = 1'b1;
        b_req = 1'b1;
        @(negedge clk);
        chk("s5_a_first", a_gnt, 1);
        chk("s5_b_wait", b_gnt, 0);
        step();
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
- Shares one single-port on-chip instruction RAM (32-bit words, 13-bit word address, byte enables, clock enable) between two requesters.
  - Port A: the CPU instruction-fetch path, read-only.
  - Port B: the program loader / debug path, read/write.
- Grants one access per cycle using 2-way round-robin, and routes RAM read data back to the owner with a valid strobe.
- A lock input lets the loader hold the RAM exclusively during image download.

Parameters:
- ADDR_W, 13, RAM word-address width.
- DATA_W, 32, data width; BE_W = DATA_W/8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  fetch read request.
- a_addr  in  ADDR_W  fetch word address.
- a_gnt  out  1  fetch request accepted this cycle.
- a_rvalid  out  1  a_rdata valid.
- a_rdata  out  DATA_W  fetch read data.
- b_req  in  1  loader request.
- b_write  in  1  1 = write, 0 = read.
- b_addr  in  ADDR_W  loader word address.
- b_be  in  BE_W  loader byte enables; write only.
- b_wdata  in  DATA_W  loader write data.
- b_lock  in  1  exclusive-access request for the loader.
- b_gnt  out  1  loader request accepted this cycle.
- b_rvalid  out  1  b_rdata valid; reads only.
- b_rdata  out  DATA_W  loader read data.
- locked  out  1  FSM is in LOAD.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  BE_W  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  to RAM.
- mem_readdata  in  DATA_W  from RAM; valid the cycle after the address is sampled.

Behaviour:
- **Grant timing.** Grants are combinational from requests and registered state. A request is accepted in the cycle its gnt is high, and the requester must hold its inputs stable until then.
- **FSM states.**
  - ARB (reset state): round-robin between A and B.
  - LOAD: only B may be granted; a_gnt is forced to 0.
- **FSM transitions.**
  - ARB→LOAD at the clock edge where b_lock=1.
  - LOAD→ARB at the clock edge where b_lock=0.
  - b_lock is evaluated only at state registration; a transaction granted in the same cycle b_lock rises still completes normally.
- **ARB arbitration.** A 1-bit priority register `prio` resets to A.
  - Only one requester asserts req: that requester is granted; `prio` is unchanged.
  - Both assert req: the side named by `prio` is granted, then `prio` flips.
  - Guarantees no starvation: worst-case wait is 1 cycle.
- **RAM drive.**
  - Idle (no grant): mem_chipselect=0, mem_write=0, mem_byteenable=0, address don't-care.
  - Grant A: mem_address=a_addr, mem_chipselect=1, mem_write=0, mem_byteenable all-ones.
  - Grant B: mem_address=b_addr, mem_chipselect=1, mem_write=b_write, mem_byteenable = b_be if writing, else all-ones; mem_writedata=b_wdata.
- **Clock enable.** mem_clken=1 except while reset=1, when it is 0.
- **Read return.**
  - Latency is exactly 1 cycle. A registered owner tag (NONE/A/B) is set on a granted read.
  - In the next cycle, x_rvalid=1 and x_rdata=mem_readdata for the owner; the other port sees rvalid=0.
  - rdata of a non-owner is don't-care; the implementation drives mem_readdata to both ports.
  - Writes produce no rvalid. Back-to-back reads sustain 1 word per cycle.
- **Reset.**
  - All registered state returns to reset values: state=ARB, prio=A, owner tag=NONE.
  - Outputs: a_rvalid=0, b_rvalid=0, locked=0; a_gnt=b_gnt=0 while reset=1.
  - A read in flight when reset asserts is discarded: no rvalid the following cycle.
- **Simultaneous events.** b_lock rising while A and B both request in ARB: this cycle is arbitrated per `prio`; LOAD applies from the next cycle.

Optional Feature:
- Macro INST_MEM_ARB_PERF_EN.
- When defined, adds outputs:
  - conflict_cnt (32 bit): increments on each cycle with a_req & b_req in ARB.
  - a_block_cnt (32 bit): increments on each cycle with a_req=1 in LOAD.
  - Both are cleared by reset and saturate at all-ones.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package inst_mem_arb_pkg holds:
  - state enum {ARB, LOAD};
  - owner enum {OWN_NONE, OWN_A, OWN_B};
  - default ADDR_W/DATA_W constants.
- One sub-module, inst_mem_arb_rr2: 2-way round-robin grant with the `prio` register, with inputs req[1:0] and enable, and output gnt[1:0].

Test Plan:
1. Reset, then A-only reads at 0x0000..0x0003 on consecutive cycles → a_gnt each cycle; a_rvalid 1 cycle later with RAM contents in order; b_rvalid stays 0.
2. B writes 0xDEADBEEF to 0x1FFF with b_be=4'b0011, then B reads 0x1FFF → mem_byteenable=0011 on the write cycle; read returns bits[15:0]=0xBEEF, upper bytes unchanged.
3. A and B both request continuously for 6 cycles from reset → grants alternate A,B,A,B,A,B; each rvalid routed to the correct port.
4. b_lock=1 while a_req=1 for 10 cycles → locked=1 from the next cycle; a_gnt=0 throughout LOAD; b_lock=0 → ARB, and A is granted on the next cycle.
5. Grant an A read, assert reset in the following cycle → a_rvalid=0; after reset, prio=A, so a simultaneous request grants A first.
6. With INST_MEM_ARB_PERF_EN defined, run scenario 3 then 4 → conflict_cnt=6 and a_block_cnt=10.
